// File: rtl/rv_iommu_ddt_walker.sv
// rv_iommu_ddt_walker: single-level DDT walk sequencer in front
// of the DDTC; also serialises DDT invalidation against walks.
module rv_iommu_ddt_walker #(
  parameter int unsigned DC_WORDS = 4,
  parameter int unsigned DID_BITS = 6,
  localparam int unsigned DC_W = 64 * DC_WORDS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      ddtp_mode_i,
  input  logic [43:0]     ddtp_ppn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [23:0]     req_did_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DC_W-1:0] rsp_dc_o,
  output logic            rsp_bare_o,
  output logic            rsp_fault_o,
  output logic [11:0]     rsp_cause_o,
  input  logic            inv_req_i,
  input  logic            inv_dv_i,
  input  logic [23:0]     inv_did_i,
  output logic            inv_ack_o,
  output logic            ddtc_flush_o,
  output logic            ddtc_flush_dv_o,
  output logic [23:0]     ddtc_flush_did_o,
  output logic            ddtc_lookup_o,
  output logic [23:0]     ddtc_lu_did_o,
  input  logic            ddtc_lu_hit_i,
  input  logic [DC_W-1:0] ddtc_lu_dc_i,
  output logic            ddtc_update_o,
  output logic [23:0]     ddtc_up_did_o,
  output logic [DC_W-1:0] ddtc_up_dc_o,
  output logic            mem_req_o,
  output logic [55:0]     mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  input  logic            mem_err_i
);

  localparam int unsigned BW =
    (DC_WORDS > 1) ? $clog2(DC_WORDS) : 1;
  localparam logic [BW-1:0] LAST = BW'(DC_WORDS - 1);
  localparam logic [55:0] DC_BYTES = 56'(8 * DC_WORDS);
  localparam logic [11:0] CAUSE_OFF = 12'd256;
  localparam logic [11:0] CAUSE_LD  = 12'd257;
  localparam logic [11:0] CAUSE_INV = 12'd258;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_REQ, MEM_WAIT, UPDATE, RESP
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   beat_q;
  logic [23:0]     did_q;
  logic [DC_W-1:0] dc_q;
  logic            bare_q;
  logic            fault_q;
  logic [11:0]     cause_q;

  logic        idle;
  logic        flush;
  logic        did_oor;
  logic        last;
  logic        word0_v;
  logic [55:0] addr;

  assign idle    = state_q == IDLE;
  assign flush   = idle & inv_req_i;
  assign did_oor = (did_q >> DID_BITS) != '0;
  assign last    = beat_q == LAST;
  // On a single-beat DC the V bit is still on the bus
  assign word0_v = (beat_q == '0) ? mem_rdata_i[0] : dc_q[0];
  assign addr    = {ddtp_ppn_i, 12'b0}
                 + 56'(did_q) * DC_BYTES
                 + 56'({beat_q, 3'b000});

  assign req_ready_o      = idle & ~inv_req_i;
  assign inv_ack_o        = flush;
  assign ddtc_flush_o     = flush;
  assign ddtc_flush_dv_o  = flush & inv_dv_i;
  assign ddtc_flush_did_o = flush ? inv_did_i : '0;

  assign ddtc_lookup_o = state_q == LOOKUP;
  assign ddtc_lu_did_o = ddtc_lookup_o ? did_q : '0;
  assign ddtc_update_o = state_q == UPDATE;
  assign ddtc_up_did_o = ddtc_update_o ? did_q : '0;
  assign ddtc_up_dc_o  = ddtc_update_o ? dc_q : '0;

  assign mem_req_o  = state_q == MEM_REQ;
  assign mem_addr_o = mem_req_o ? addr : '0;

  assign rsp_valid_o = state_q == RESP;
  assign rsp_dc_o    = rsp_valid_o ? dc_q : '0;
  assign rsp_bare_o  = rsp_valid_o & bare_q;
  assign rsp_fault_o = rsp_valid_o & fault_q;
  assign rsp_cause_o = rsp_valid_o ? cause_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      did_q   <= '0;
      dc_q    <= '0;
      bare_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!inv_req_i && req_valid_i) begin
            did_q   <= req_did_i;
            dc_q    <= '0;
            beat_q  <= '0;
            bare_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= '0;
            unique case (ddtp_mode_i)
              2'd1: begin
                bare_q  <= 1'b1;
                state_q <= RESP;
              end
              2'd2: state_q <= LOOKUP;
              default: begin
                fault_q <= 1'b1;
                cause_q <= CAUSE_OFF;
                state_q <= RESP;
              end
            endcase
          end
        end
        LOOKUP: begin
          if (ddtc_lu_hit_i) begin
            dc_q    <= ddtc_lu_dc_i;
            state_q <= RESP;
          end else if (did_oor) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_INV;
            state_q <= RESP;
          end else begin
            beat_q  <= '0;
            state_q <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_gnt_i) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              dc_q    <= '0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_LD;
              state_q <= RESP;
            end else if (last && !word0_v) begin
              dc_q    <= '0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_INV;
              state_q <= RESP;
            end else begin
              dc_q[int'(beat_q)*64 +: 64] <= mem_rdata_i;
              if (last) begin
                state_q <= UPDATE;
              end else begin
                beat_q  <= beat_q + 1'b1;
                state_q <= MEM_REQ;
              end
            end
          end
        end
        UPDATE: state_q <= RESP;
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iommu_ddt_walker.sv
// tb_rv_iommu_ddt_walker: directed bench with a response
// scoreboard, a DDTC stub and a one-outstanding memory model.
module tb_rv_iommu_ddt_walker;

  localparam int DC_W = 256;
  localparam logic [55:0] BASE = 56'h100000;
  localparam logic [255:0] HIT_DC =
    {4{64'hFEED_0000_CAFE_0001}};

  typedef struct packed {
    logic [255:0] dc;
    logic         bare;
    logic         fault;
    logic [11:0]  cause;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [1:0]      ddtp_mode_i = 2'd2;
  logic [43:0]     ddtp_ppn_i = 44'h100;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [23:0]     req_did_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [DC_W-1:0] rsp_dc_o;
  logic            rsp_bare_o;
  logic            rsp_fault_o;
  logic [11:0]     rsp_cause_o;
  logic            inv_req_i = 1'b0;
  logic            inv_dv_i = 1'b0;
  logic [23:0]     inv_did_i = '0;
  logic            inv_ack_o;
  logic            ddtc_flush_o;
  logic            ddtc_flush_dv_o;
  logic [23:0]     ddtc_flush_did_o;
  logic            ddtc_lookup_o;
  logic [23:0]     ddtc_lu_did_o;
  logic            ddtc_lu_hit_i = 1'b0;
  logic [DC_W-1:0] ddtc_lu_dc_i = HIT_DC;
  logic            ddtc_update_o;
  logic [23:0]     ddtc_up_did_o;
  logic [DC_W-1:0] ddtc_up_dc_o;
  logic            mem_req_o;
  logic [55:0]     mem_addr_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_rvalid_i = 1'b0;
  logic [63:0]     mem_rdata_i = '0;
  logic            mem_err_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int lu_cnt = 0;
  int up_cnt = 0;
  int ack_cnt = 0;
  logic [23:0]  up_did = '0;
  logic [255:0] up_dc = '0;
  logic [55:0]  got_q[$];
  rsp_t         exp_q[$];
  logic [55:0]  zero_addr = '1;
  logic [55:0]  err_addr = '1;

  rv_iommu_ddt_walker #(
    .DC_WORDS(4),
    .DID_BITS(6)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .ddtp_mode_i(ddtp_mode_i),
    .ddtp_ppn_i(ddtp_ppn_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_did_i(req_did_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dc_o(rsp_dc_o),
    .rsp_bare_o(rsp_bare_o),
    .rsp_fault_o(rsp_fault_o),
    .rsp_cause_o(rsp_cause_o),
    .inv_req_i(inv_req_i),
    .inv_dv_i(inv_dv_i),
    .inv_did_i(inv_did_i),
    .inv_ack_o(inv_ack_o),
    .ddtc_flush_o(ddtc_flush_o),
    .ddtc_flush_dv_o(ddtc_flush_dv_o),
    .ddtc_flush_did_o(ddtc_flush_did_o),
    .ddtc_lookup_o(ddtc_lookup_o),
    .ddtc_lu_did_o(ddtc_lu_did_o),
    .ddtc_lu_hit_i(ddtc_lu_hit_i),
    .ddtc_lu_dc_i(ddtc_lu_dc_i),
    .ddtc_update_o(ddtc_update_o),
    .ddtc_up_did_o(ddtc_up_did_o),
    .ddtc_up_dc_o(ddtc_up_dc_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mword(logic [55:0] a);
    return (a == zero_addr) ? 64'h0 : {a, 8'h01};
  endfunction

  function automatic logic [255:0] mdc(logic [23:0] d);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[i*64 +: 64] =
        mword(BASE + 56'(d) * 56'd32 + 56'(8 * i));
    return r;
  endfunction

  function automatic rsp_t mk(logic [255:0] dc, logic bare,
                              logic fault, logic [11:0] cause);
    rsp_t r;
    r.dc = dc;
    r.bare = bare;
    r.fault = fault;
    r.cause = cause;
    return r;
  endfunction

  // memory: grant in the request cycle, data one cycle later
  initial begin
    logic        pend;
    logic [55:0] pa;
    pend = 1'b0;
    pa = '0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = pend;
      mem_rdata_i  = pend ? mword(pa) : '0;
      mem_err_i    = pend && (pa == err_addr);
      pend = 1'b0;
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
        mem_gnt_i = 1'b1;
        pend = 1'b1;
        pa = mem_addr_o;
        hs_cnt++;
        got_q.push_back(mem_addr_o);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (ddtc_lookup_o) lu_cnt++;
    if (inv_ack_o) ack_cnt++;
    if (ddtc_update_o) begin
      up_cnt++;
      up_did = ddtc_up_did_o;
      up_dc = ddtc_up_dc_o;
    end
  end

  task automatic chk(string tag, logic [255:0] obs,
                     logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(logic [23:0] d);
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_did_i = d;
    #1;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready_o)
      chk("accept_timeout", 256'(req_ready_o), 256'(1));
    @(posedge clk);
  endtask

  task automatic wait_rsp(string tag, int hold,
                          output int lat);
    rsp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid_i = 1'b0;
      lat++;
    end while (!rsp_valid_o && lat < 200);
    chk({tag, "_valid"}, 256'(rsp_valid_o), 256'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_dc"}, rsp_dc_o, e.dc);
    chk({tag, "_bare"}, 256'(rsp_bare_o), 256'(e.bare));
    chk({tag, "_fault"}, 256'(rsp_fault_o), 256'(e.fault));
    chk({tag, "_cause"}, 256'(rsp_cause_o), 256'(e.cause));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, 256'(rsp_valid_o), 256'(1));
      chk({tag, "_hold_dc"}, rsp_dc_o, e.dc);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int lat, n, h0, l0, u0, a0;
    logic [55:0] ea[4];
    ea[0] = 56'h100060;
    ea[1] = 56'h100068;
    ea[2] = 56'h100070;
    ea[3] = 56'h100078;

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", 256'(req_ready_o), 256'(1));
    chk("rst_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_ctl", 256'({inv_ack_o, ddtc_flush_o,
        ddtc_lookup_o, ddtc_update_o, rsp_fault_o,
        rsp_bare_o}), 256'(0));

    ddtc_lu_hit_i = 1'b1;
    exp_q.push_back(mk(HIT_DC, 1'b0, 1'b0, 12'd0));
    h0 = hs_cnt; l0 = lu_cnt; u0 = up_cnt;
    send(24'd5);
    wait_rsp("hit", 1, lat);
    chk("hit_latency", 256'(lat), 256'(2));
    chk("hit_lookups", 256'(lu_cnt - l0), 256'(1));
    chk("hit_no_mem", 256'(hs_cnt - h0), 256'(0));
    chk("hit_no_upd", 256'(up_cnt - u0), 256'(0));

    ddtc_lu_hit_i = 1'b0;
    got_q.delete();
    exp_q.push_back(mk(mdc(24'd3), 1'b0, 1'b0, 12'd0));
    u0 = up_cnt;
    send(24'd3);
    wait_rsp("miss", 0, lat);
    chk("miss_beats", 256'(got_q.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("miss_addr%0d", i),
          256'((got_q.size() > i) ? got_q[i] : '1),
          256'(ea[i]));
    chk("miss_upd", 256'(up_cnt - u0), 256'(1));
    chk("miss_upd_did", 256'(up_did), 256'(3));
    chk("miss_upd_dc", up_dc, mdc(24'd3));

    zero_addr = BASE + 56'h40;
    exp_q.push_back(mk('0, 1'b0, 1'b1, 12'd258));
    h0 = hs_cnt; u0 = up_cnt;
    send(24'd2);
    wait_rsp("vbit0", 0, lat);
    chk("vbit0_beats", 256'(hs_cnt - h0), 256'(4));
    chk("vbit0_no_upd", 256'(up_cnt - u0), 256'(0));
    zero_addr = '1;

    err_addr = BASE + 56'h28;
    exp_q.push_back(mk('0, 1'b0, 1'b1, 12'd257));
    h0 = hs_cnt; u0 = up_cnt;
    send(24'd1);
    wait_rsp("memerr", 0, lat);
    chk("memerr_beats", 256'(hs_cnt - h0), 256'(2));
    chk("memerr_no_upd", 256'(up_cnt - u0), 256'(0));
    err_addr = '1;

    exp_q.push_back(mk(mdc(24'd4), 1'b0, 1'b0, 12'd0));
    a0 = ack_cnt; h0 = hs_cnt;
    send(24'd4);
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    @(negedge clk);
    inv_req_i = 1'b1;
    inv_dv_i = 1'b1;
    inv_did_i = 24'd7;
    wait_rsp("inv_walk", 0, lat);
    chk("inv_no_early_ack", 256'(ack_cnt - a0), 256'(0));
    req_valid_i = 1'b1;
    req_did_i = 24'd9;
    ddtc_lu_hit_i = 1'b1;
    #1;
    chk("inv_ack", 256'(inv_ack_o), 256'(1));
    chk("inv_flush", 256'({ddtc_flush_o, ddtc_flush_dv_o}),
        256'(2'b11));
    chk("inv_flush_did", 256'(ddtc_flush_did_o), 256'(7));
    chk("inv_stall", 256'(req_ready_o), 256'(0));
    exp_q.push_back(mk(HIT_DC, 1'b0, 1'b0, 12'd0));
    @(posedge clk);
    @(negedge clk);
    inv_req_i = 1'b0;
    inv_dv_i = 1'b0;
    inv_did_i = '0;
    #1;
    chk("inv_then_ready", 256'(req_ready_o), 256'(1));
    send(24'd9);
    wait_rsp("post_inv", 0, lat);
    chk("inv_ack_once", 256'(ack_cnt - a0), 256'(1));

    ddtc_lu_hit_i = 1'b0;
    exp_q.push_back(mk('0, 1'b0, 1'b1, 12'd258));
    h0 = hs_cnt; l0 = lu_cnt;
    send(24'h40);
    wait_rsp("did_oor", 0, lat);
    chk("did_oor_no_mem", 256'(hs_cnt - h0), 256'(0));
    chk("did_oor_lookup", 256'(lu_cnt - l0), 256'(1));

    ddtp_mode_i = 2'd0;
    exp_q.push_back(mk('0, 1'b0, 1'b1, 12'd256));
    l0 = lu_cnt;
    send(24'd6);
    wait_rsp("off", 0, lat);
    chk("off_no_lookup", 256'(lu_cnt - l0), 256'(0));

    ddtp_mode_i = 2'd3;
    exp_q.push_back(mk('0, 1'b0, 1'b1, 12'd256));
    send(24'd6);
    wait_rsp("mode3", 0, lat);

    ddtp_mode_i = 2'd1;
    exp_q.push_back(mk('0, 1'b1, 1'b0, 12'd0));
    l0 = lu_cnt;
    send(24'd6);
    wait_rsp("bare", 0, lat);
    chk("bare_no_lookup", 256'(lu_cnt - l0), 256'(0));

    // reset during a walk, with the beat still in flight
    ddtp_mode_i = 2'd2;
    h0 = hs_cnt;
    send(24'd3);
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    req_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_rsp", 256'(rsp_valid_o), 256'(0));
    chk("midrst_ready", 256'(req_ready_o), 256'(1));
    chk("midrst_mem", 256'(mem_req_o), 256'(0));

    ddtc_lu_hit_i = 1'b1;
    exp_q.push_back(mk(HIT_DC, 1'b0, 1'b0, 12'd0));
    send(24'd5);
    wait_rsp("after_rst", 0, lat);
    chk("after_rst_lat", 256'(lat), 256'(2));
    chk("sb_empty", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
